line_burst_adaptor: RTL

Responder on the 256-bit cache-line memory interface, on the opposite side from the eviction write buffer. It accepts one line read or line write from the upstream requester and converts it into a 4-beat × 64-bit burst on the physical-memory bus. It returns one `resp_o` pulse per line, after the last beat.

---
 rtl/mem_if_pkg.sv | 22 ++
 rtl/line_burst_adaptor_if.sv | 43 ++++
 rtl/line_burst_adaptor.sv | 96 +++++++++
 3 files changed

// File: rtl/mem_if_pkg.sv
// Shared definitions for the cache-line memory interface and its burst adaptor:
// default widths, adaptor state encoding and the beat-index type.
package mem_if_pkg;

  localparam int LINE_W_DEFAULT = 256;
  localparam int BEAT_W_DEFAULT = 64;

  typedef enum logic [1:0] {
    IDLE,
    RD_BURST,
    WR_BURST,
    DONE
  } state_t;

  typedef logic [1:0] beat_idx_t;

  // Clears the byte-offset bits of a line address.
  function automatic logic [31:0] line_align(input logic [31:0] addr, input int line_w);
    return addr & ~32'(line_w / 8 - 1);
  endfunction

endpackage

// File: rtl/line_burst_adaptor_if.sv
// Cache-line request interface (requester <-> adaptor) and physical-memory
// burst interface (adaptor <-> memory).
interface line_if #(
  parameter int LINE_W = mem_if_pkg::LINE_W_DEFAULT
) ();
  logic [31:0]       line_addr_i;
  logic              line_read_i;
  logic              line_write_i;
  logic [LINE_W-1:0] line_wdata_i;
  logic [LINE_W-1:0] line_rdata_o;
  logic              resp_o;

  modport master (
    output line_addr_i, line_read_i, line_write_i, line_wdata_i,
    input  line_rdata_o, resp_o
  );

  modport slave (
    input  line_addr_i, line_read_i, line_write_i, line_wdata_i,
    output line_rdata_o, resp_o
  );
endinterface

interface burst_if #(
  parameter int BEAT_W = mem_if_pkg::BEAT_W_DEFAULT
) ();
  logic [31:0]       burst_addr_o;
  logic              burst_read_o;
  logic              burst_write_o;
  logic [BEAT_W-1:0] burst_wdata_o;
  logic [BEAT_W-1:0] burst_rdata_i;
  logic              burst_resp_i;

  modport master (
    output burst_addr_o, burst_read_o, burst_write_o, burst_wdata_o,
    input  burst_rdata_i, burst_resp_i
  );

  modport slave (
    input  burst_addr_o, burst_read_o, burst_write_o, burst_wdata_o,
    output burst_rdata_i, burst_resp_i
  );
endinterface

// File: rtl/line_burst_adaptor.sv
// Converts one cache-line read or write into a BEATS-beat burst on the memory
// bus and pulses resp_o for one cycle once the last beat has been taken.
module line_burst_adaptor
  import mem_if_pkg::*;
#(
  parameter int LINE_W = LINE_W_DEFAULT,
  parameter int BEAT_W = BEAT_W_DEFAULT
) (
  input  logic     clk,
  input  logic     rst,
  line_if.slave    line,
  burst_if.master  burst
);

  localparam int        BEATS     = LINE_W / BEAT_W;
  localparam beat_idx_t LAST_BEAT = beat_idx_t'(BEATS - 1);

  state_t            state_reg, state_next;
  beat_idx_t         cnt_reg, cnt_next;
  logic [31:0]       addr_reg, addr_next;
  logic [LINE_W-1:0] rbuf_reg, rbuf_next;
  logic [LINE_W-1:0] wline_reg, wline_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      addr_reg  <= '0;
      rbuf_reg  <= '0;
      wline_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      addr_reg  <= addr_next;
      rbuf_reg  <= rbuf_next;
      wline_reg <= wline_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    addr_next  = addr_reg;
    rbuf_next  = rbuf_reg;
    wline_next = wline_reg;

    unique case (state_reg)
      IDLE: begin
        // Read has priority when both requests are raised together.
        if (line.line_read_i) begin
          state_next = RD_BURST;
          addr_next  = line_align(line.line_addr_i, LINE_W);
          cnt_next   = '0;
        end else if (line.line_write_i) begin
          state_next = WR_BURST;
          addr_next  = line_align(line.line_addr_i, LINE_W);
          wline_next = line.line_wdata_i;
          cnt_next   = '0;
        end
      end
      RD_BURST: begin
        if (burst.burst_resp_i) begin
          rbuf_next[int'(cnt_reg)*BEAT_W +: BEAT_W] = burst.burst_rdata_i;
          cnt_next = cnt_reg + 1'b1;
          if (cnt_reg == LAST_BEAT) begin
            state_next = DONE;
          end
        end
      end
      WR_BURST: begin
        if (burst.burst_resp_i) begin
          cnt_next = cnt_reg + 1'b1;
          if (cnt_reg == LAST_BEAT) begin
            state_next = DONE;
          end
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Moore outputs: all decoded from registers only.
  assign burst.burst_read_o  = (state_reg == RD_BURST);
  assign burst.burst_write_o = (state_reg == WR_BURST);
  assign burst.burst_addr_o  = addr_reg;
  assign burst.burst_wdata_o = (state_reg == WR_BURST) ?
                               wline_reg[int'(cnt_reg)*BEAT_W +: BEAT_W] : '0;
  assign line.resp_o         = (state_reg == DONE);
  assign line.line_rdata_o   = rbuf_reg;

endmodule
